// File: rtl/fifo_byte_reader.sv
// Unpacks WIDTH-bit FIFO words into a byte stream, LSB first, with valid/ready output.
// Optional word counter enabled by defining FIFO_BYTE_READER_STATS_EN.
module fifo_byte_reader #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_re,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
`ifdef FIFO_BYTE_READER_STATS_EN
  ,
  output logic [15:0]      word_count
`endif
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e           r_state, w_state_d;
  logic [IdxW-1:0]  r_idx, w_idx_d;
  logic [WIDTH-1:0] r_shift, w_shift_d;
  logic             w_accept;
  logic             w_last;

  always_comb begin
    w_accept  = !rst && (r_state == StSend) && out_ready;
    w_last    = (r_idx == LastIdx);
    // Reload on the final accepted byte keeps the stream bubble-free across words.
    fifo_re   = !rst && en && !fifo_empty &&
                ((r_state == StIdle) || (w_accept && w_last));
    out_valid = !rst && (r_state == StSend);
    busy      = out_valid;
    out_data  = r_shift[7:0];

    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_shift_d = r_shift;
    if (fifo_re) begin
      w_state_d = StSend;
      w_idx_d   = '0;
      w_shift_d = fifo_rdata;
    end else if (w_accept) begin
      if (w_last) begin
        w_state_d = StIdle;
      end else begin
        w_idx_d   = r_idx + IdxW'(1);
        w_shift_d = r_shift >> 8;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_shift <= w_shift_d;
    end
  end

`ifdef FIFO_BYTE_READER_STATS_EN
  logic [15:0] r_word_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_count <= '0;
    end else if (fifo_re) begin
      r_word_count <= r_word_count + 16'd1;
    end
  end

  assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Scoreboard bench for fifo_byte_reader: directed scenarios then random traffic,
// checked against a byte-queue / bytes-remaining reference model.
module tb_fifo_byte_reader;

  localparam int NB  = 4;
  localparam int CAP = 4096;

  logic        clk = 1'b0;
  logic        rst, en, fifo_empty, fifo_re, out_valid, out_ready, busy;
  logic [31:0] fifo_rdata;
  logic [7:0]  out_data;

  always #5 clk = ~clk;

`ifdef FIFO_BYTE_READER_STATS_EN
  logic [15:0] word_count;
  logic        s_rst, s_re, s_valid, s_busy;
  logic [7:0]  s_data;
  logic [15:0] s_wc;
  int          stat_ticks = 0;
`endif

  fifo_byte_reader #(.WIDTH(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_re    (fifo_re),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
`ifdef FIFO_BYTE_READER_STATS_EN
    ,
    .word_count (word_count)
`endif
  );

`ifdef FIFO_BYTE_READER_STATS_EN
  // Always-full FIFO and always-ready sink: one pop per cycle.
  fifo_byte_reader #(.WIDTH(8)) u_stat (
    .clk        (clk),
    .rst        (s_rst),
    .en         (1'b1),
    .fifo_empty (1'b0),
    .fifo_rdata (8'h5A),
    .fifo_re    (s_re),
    .out_valid  (s_valid),
    .out_ready  (1'b1),
    .out_data   (s_data),
    .busy       (s_busy),
    .word_count (s_wc)
  );
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] wmem [CAP];
  int          wr = 0;
  int          fifo_rd = 0;
  bit          pop_flag = 1'b0;
  int          rem = 0;
  int          exp_rd = 0;
  bit          prev_rst = 1'b1;
  logic [15:0] wc_model = 16'd0;

  // Monitor and reference model: rem = bytes of the held word not yet accepted.
  always @(negedge clk) begin
    logic       exp_re, exp_valid, acc;
    logic [7:0] eb;
    exp_re    = !rst && en && !fifo_empty && (rem == 0 || (rem == 1 && out_ready));
    exp_valid = !rst && (rem != 0);
    acc       = exp_valid && out_ready;

    checks++;
    if (fifo_re !== exp_re) begin
      errors++;
      $display("FAIL fifo_re t=%0t got %b want %b", $time, fifo_re, exp_re);
    end
    checks++;
    if (out_valid !== exp_valid) begin
      errors++;
      $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, exp_valid);
    end
    checks++;
    if (busy !== exp_valid) begin
      errors++;
      $display("FAIL busy t=%0t got %b want %b", $time, busy, exp_valid);
    end
    if (prev_rst) begin
      checks++;
      if (out_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_data t=%0t got %h want 00", $time, out_data);
      end
    end
    if (acc) begin
      checks++;
      if (exp_rd >= wr * NB) begin
        errors++;
        $display("FAIL byte_underflow t=%0t got %h want none", $time, out_data);
      end else begin
        eb = wmem[exp_rd / NB][8 * (exp_rd % NB) +: 8];
        if (out_data !== eb) begin
          errors++;
          $display("FAIL out_data t=%0t byte#%0d got %h want %h", $time, exp_rd, out_data, eb);
        end
      end
      exp_rd++;
    end
`ifdef FIFO_BYTE_READER_STATS_EN
    checks++;
    if (word_count !== wc_model) begin
      errors++;
      $display("FAIL word_count t=%0t got %0d want %0d", $time, word_count, wc_model);
    end
    if (rst) wc_model = 16'd0;
    else if (exp_re) wc_model = wc_model + 16'd1;
`endif

    pop_flag = fifo_re && !fifo_empty;
    if (rst) begin
      exp_rd += rem;  // partially sent word is dropped
      rem = 0;
    end else if (exp_re) begin
      rem = NB;
    end else if (acc) begin
      rem--;
    end
    prev_rst = rst;
  end

  function automatic void refresh();
    fifo_empty = (fifo_rd == wr);
    fifo_rdata = fifo_empty ? 32'h0 : wmem[fifo_rd];
  endfunction

  task automatic push(input logic [31:0] w);
    if (wr < CAP) begin
      wmem[wr] = w;
      wr++;
    end
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_flag && fifo_rd < wr) fifo_rd++;
`ifdef FIFO_BYTE_READER_STATS_EN
    stat_ticks++;
`endif
    refresh();
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
`ifdef FIFO_BYTE_READER_STATS_EN
    s_rst = 1'b1;
`endif
    refresh();
    repeat (3) tick();
    rst = 1'b0;
`ifdef FIFO_BYTE_READER_STATS_EN
    s_rst = 1'b0;
    stat_ticks = 0;
`endif

    // Single word, continuous ready
    en = 1'b1; out_ready = 1'b1;
    push(32'hA1B2C3D4);
    repeat (8) tick();

    // Two queued words back to back
    push(32'h04030201);
    push(32'h08070605);
    repeat (12) tick();

    // Stall on byte 1
    push(32'h11223344);
    tick();
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (5) tick();

    // en falls after byte 0 with a second word waiting
    push(32'hDEADBEEF);
    push(32'hCAFEF00D);
    tick();
    en = 1'b0;
    repeat (6) tick();
    en = 1'b1;
    repeat (6) tick();

    // Reset at idx 2
    push(32'h55667788);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(32'h99AABBCC);
    repeat (6) tick();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2) == 0) push($urandom);
      en        = ($urandom_range(7) != 0);
      out_ready = ($urandom_range(3) != 0);
      rst       = ($urandom_range(99) == 0);
      tick();
    end

    // Drain
    rst = 1'b0; en = 1'b1; out_ready = 1'b1;
    n = 0;
    while ((fifo_rd != wr || rem != 0) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (fifo_rd != wr || rem != 0) begin
      errors++;
      $display("FAIL drain_timeout got popped=%0d rem=%0d want popped=%0d rem=0",
               fifo_rd, rem, wr);
    end
    checks++;
    if (exp_rd != wr * NB) begin
      errors++;
      $display("FAIL byte_total got %0d want %0d", exp_rd, wr * NB);
    end

`ifdef FIFO_BYTE_READER_STATS_EN
    while (stat_ticks < 65537) tick();
    checks++;
    if (s_wc !== 16'd1) begin
      errors++;
      $display("FAIL word_count_wrap got %0d want 1", s_wc);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
